// File: rtl/enums_pkg.sv
// Shared UART constants: register offsets, STATUS bit positions and TX FSM states.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package enums_pkg;

    localparam logic [1:0] UART_REG_DATA    = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_DIVIDER = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_PARITY    = 4;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; read data is the head entry, valid whenever not empty.
// Push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);

    // Pointers are exactly log2(DEPTH) wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: FIFO-buffered bytes serialised 8N1 (8E1 with UART_TX_PARITY_EN).
// DATA writes pop one edge later; writes to a full FIFO without a same-cycle pop drop and set overflow.
module uart_tx_peripheral
    import enums_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t state_q, state_d;
    logic [15:0] div_q, div_d, lat_div_q, lat_div_d, bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        par_q, par_d, ovf_q, ovf_d;
    logic        fifo_full, fifo_empty, fifo_pop, data_wr, bit_end, busy;
    logic [7:0]  fifo_dat;
    logic [CW-1:0] fifo_count;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{address[31:4], address[1:0], write_data[31:16]};
    assign data_wr     = write_enable && (address[3:2] == UART_REG_DATA);
    assign bit_end     = (bit_cnt_q == lat_div_q);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (data_wr),
        .push_dat_i (write_data[7:0]),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_div_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            div_q     <= DEFAULT_DIVIDER;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_div_q <= lat_div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_div_d = lat_div_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        if (state_q == ST_IDLE) begin
            // Divider is captured per frame so mid-frame writes only affect the next one.
            if (!fifo_empty) begin
                state_d   = ST_START;
                shreg_d   = fifo_dat;
                par_d     = ^fifo_dat;
                lat_div_d = div_q;
                bit_cnt_d = '0;
                bit_idx_d = '0;
            end
        end else if (!bit_end) begin
            bit_cnt_d = bit_cnt_q + 16'd1;
        end else begin
            bit_cnt_d = '0;
            case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA: begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = ST_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: state_d = ST_STOP;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx       = 1'b1;
        busy     = (state_q != ST_IDLE);
        fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = par_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (write_enable && address[3:2] == UART_REG_DIVIDER) div_d = write_data[15:0];
        if (write_enable && address[3:2] == UART_REG_STATUS)  ovf_d = 1'b0;
        if (data_wr && fifo_full && !fifo_pop)                ovf_d = 1'b1;
    end

    assign irq = fifo_empty && !busy;

    always_comb begin
        status                          = '0;
        status[STAT_FULL]               = fifo_full;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_BUSY]               = busy;
        status[STAT_OVERFLOW]           = ovf_q;
`ifdef UART_TX_PARITY_EN
        status[STAT_PARITY]             = 1'b1;
`endif
        status[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
        read_data = '0;
        if (read_enable) begin
            case (address[3:2])
                UART_REG_STATUS:  read_data = status;
                UART_REG_DIVIDER: read_data = {16'h0000, div_q};
                default:          read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral: frame-level reference model compared every cycle, plus literal checks.
module tb_uart_tx_peripheral;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic        tx, irq;

    int checks = 0;
    int errors = 0;

    uart_tx_peripheral #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVIDER(16'd867)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .read_data    (read_data),
        .tx           (tx),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue and a whole-frame bit vector indexed by elapsed cycles.
    logic [7:0] mq[$];
    int  m_div = 867;
    bit  m_ovf = 0;
    bit  m_act = 0;
    int  m_el = 0, m_total = 0, m_bitlen = 1, m_nb = 0;
    bit  m_bits[12];
    logic [7:0] m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_div = 867;
            m_ovf = 0;
            m_act = 0;
            m_el  = 0;
        end else begin
            if (m_act) begin
                m_el++;
                if (m_el == m_total) m_act = 0;
            end else if (mq.size() > 0) begin
                m_b      = mq.pop_front();
                m_bitlen = m_div + 1;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = m_b[i];
                m_nb = 9;
`ifdef UART_TX_PARITY_EN
                m_bits[9] = ^m_b;
                m_nb = 10;
`endif
                m_bits[m_nb] = 1'b1;
                m_total = (m_nb + 1) * m_bitlen;
                m_el  = 0;
                m_act = 1;
            end
            if (write_enable) begin
                case (address[3:2])
                    2'd0: if (mq.size() < DEPTH) mq.push_back(write_data[7:0]); else m_ovf = 1;
                    2'd1: m_ovf = 0;
                    2'd2: m_div = int'(write_data[15:0]);
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == DEPTH);
        s[1] = (mq.size() == 0);
        s[2] = m_act;
        s[3] = m_ovf;
`ifdef UART_TX_PARITY_EN
        s[4] = 1'b1;
`endif
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    logic [31:0] exp_rd;
    always @(negedge clk) begin
        chk("model_tx", {31'b0, tx}, {31'b0, m_act ? m_bits[m_el / m_bitlen] : 1'b1});
        chk("model_irq", {31'b0, irq}, {31'b0, !m_act && mq.size() == 0});
        exp_rd = '0;
        if (read_enable) begin
            case (address[3:2])
                2'd1:    exp_rd = exp_status();
                2'd2:    exp_rd = 32'(m_div);
                default: exp_rd = '0;
            endcase
        end
        chk("model_read_data", read_data, exp_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] reg_sel, input logic [31:0] d);
        address      = {28'h0, reg_sel, 2'b00};
        write_data   = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [1:0] reg_sel, output logic [31:0] d);
        address     = {28'h0, reg_sel, 2'b00};
        read_enable = 1'b1;
        @(negedge clk);
        d = read_data;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000 && !irq; i++) tick();
        chk(name, {31'b0, irq}, 32'd1);
    endtask

    logic [31:0] d;
    bit          a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit          p07_bits[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    int          lows;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_irq", {31'b0, irq}, 32'd1);
        chk("reset_read_data", read_data, 32'd0);
        rst_n = 1'b1;
        tick();
        rd(2'd1, d); chk("reset_status", d, 32'h0000_0002);
        rd(2'd2, d); chk("reset_divider", d, 32'd867);

        // 0xA5 at DIVIDER=3: 4-cycle bits, mid-bit sampling.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h0000_00A5);
        chk("a5_tx_still_idle", {31'b0, tx}, 32'd1);
        tick();
        chk("a5_tx_falls", {31'b0, tx}, 32'd0);
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), {31'b0, tx}, {31'b0, a5_bits[k]});
            if (k < 9) repeat (4) tick();
        end
        tick();
        chk("a5_irq_before_end", {31'b0, irq}, 32'd0);
        tick();
        chk("a5_irq_after_40", {31'b0, irq}, 32'd1);

        // DIVIDER=0: 10 back-to-back writes, the 10th overflows.
        wr(2'd2, 32'd0);
        for (int i = 0; i < 10; i++) wr(2'd0, 32'h10 + 32'(i));
        rd(2'd1, d); chk("ovf_set", {31'b0, d[3]}, 32'd1);
        wr(2'd1, 32'd0);
        rd(2'd1, d); chk("ovf_cleared", {31'b0, d[3]}, 32'd0);
        wait_idle("drain_burst");

        // DIVIDER change mid-frame only affects the following frame.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h0000_003C);
        wr(2'd0, 32'h0000_0081);
        repeat (10) tick();
        wr(2'd2, 32'd1);
        rd(2'd2, d); chk("divider_mid_frame", d, 32'd1);
        wait_idle("drain_div_change");

        // Reset during DATA bit 3 of 0x00, with another byte queued.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h0000_0000);
        wr(2'd0, 32'h0000_0055);
        repeat (16) tick();
        chk("bit3_low", {31'b0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_tx", {31'b0, tx}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rd(2'd1, d);
        chk("post_reset_count", {24'b0, d[15:8]}, 32'd0);
        chk("post_reset_status", d, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx == 1'b0) lows++;
        end
        chk("no_frame_after_reset", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h0000_0007);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk($sformatf("p07_bit%0d", k), {31'b0, tx}, {31'b0, p07_bits[k]});
        end
        tick();
        chk("p07_irq_after_11", {31'b0, irq}, 32'd1);
        rd(2'd1, d); chk("status_parity_bit", {31'b0, d[4]}, 32'd1);
`else
        rd(2'd1, d); chk("status_parity_bit", {31'b0, d[4]}, 32'd0);
        chk("p07_table_unused", {31'b0, p07_bits[9]}, {31'b0, irq});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
